wallace_mult_pipe: RTL
======================

// Module: wallace_mult_pipe
// PURPOSE
//  Parametrised, pipelined W x W Wallace-tree multiplier with a valid/ready handshake.
//  Per-transaction mode selects unsigned or two's-complement (Baugh-Wooley) operands.
//  Successor to the fixed 8-bit combinational signed multiplier. Sits between
//  handshake-based datapath blocks (e.g. MAC/filter stages) that need full-rate
//  throughput and backpressure.
// PARAMETERS
//  W       8   operand width in bits; legal range 4..32
//  STAGES  3   pipeline register stages from accept to result; legal range 1..4
// PORTS
//  clk        in   1     single clock; all state updates on the rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  in_valid   in   1     x, y and sgn are valid this cycle
//  in_ready   out  1     block accepts an operand pair this cycle
//  x          in   W     multiplicand
//  y          in   W     multiplier
//  sgn        in   1     1 = both operands two's complement; 0 = both unsigned
//  out_valid  out  1     p is valid
//  out_ready  in   1     consumer takes p this cycle
//  p          out  2W    full-precision product; signed or unsigned per captured sgn
// BEHAVIOUR
//  - Reset (rst_n low, async): all stage valid flags clear to 0; out_valid=0; p=0.
//    in_ready is 1 from the first cycle after rst_n rises. In-flight products are discarded.
//  - Accept: occurs when in_valid && in_ready at a rising edge. sgn is captured with
//    the operands and travels with them; a mode change between consecutive
//    transactions is legal and needs no bubble.
//  - Latency: exactly STAGES cycles from accept to out_valid, with no stall.
//  - Throughput: one product per cycle while out_ready=1.
//  - Stage handshake: each stage i has valid v[i].
//    - ready[i] = !v[i] || ready[i+1]; ready[STAGES] = out_ready; in_ready = ready[1].
//    - When a stage's ready is high, it loads from upstream; otherwise it holds.
//    - Bubbles collapse: an empty stage accepts even when downstream is stalled.
//  - Stall: while out_valid && !out_ready, p and out_valid hold stable.
//    The pipeline fills up to STAGES entries; then in_ready=0.
//    No transaction is dropped or duplicated.
//  - Simultaneous events: when the pipe is full and out_ready=1 in the same cycle as
//    in_valid=1, the block drains one and accepts one in that cycle.
//  - Arithmetic:
//    - sgn=1: Baugh-Wooley form. Invert the MSB-row/MSB-column partial products, add
//      the constant 1 at weights W and 2W-1, and drop the carry out of bit 2W-1.
//      p = $signed(x) * $signed(y) mod 2^2W.
//    - sgn=0: plain AND partial products; no inversion, no constants;
//      p = x * y exactly.
//    - Results are bit-exact for every operand pair; no rounding or saturation.
//  - Reduction: W partial-product rows reduce through 3:2 carry-save levels to two
//    rows, then one ripple/CPA adds them.
//    - The CSA levels are distributed evenly over the first STAGES-1 register
//      boundaries. The CPA is in the last stage.
//    - With STAGES=1, all logic sits ahead of the single output register.
//  - Reset mid-operation: asserting rst_n mid-stream clears all valid flags
//    immediately (async), and out_valid drops in the same cycle.
// STRUCTURE
//  - Package mult_pkg holds:
//    - localparam function csa_depth(W), the number of 3:2 levels to reach 2 rows;
//    - the constant-correction vector builder for Baugh-Wooley;
//    - a stage-boundary table mapping CSA levels to pipeline stages.
//  - One sub-module, csa_row: a parametrised-width row of full adders
//    (3 vectors in -> sum, carry<<1). It is instantiated per level via generate.
//  - Partial-product generation and the CPA stay inline in wallace_mult_pipe.
// TESTING
//  1. sgn=1, W=8: x=0x80, y=0x80 -> p=0x4000. x=0xFF, y=0x01 -> p=0xFFFF.
//     x=0x7F, y=0x80 -> p=0xC080.
//  2. sgn=0, W=8: x=0xFF, y=0xFF -> p=0xFE01. x=0x00, y=0xA5 -> p=0x0000.
//     Back-to-back with the sgn=1 case 0xFF*0xFF -> p=0x0001.
//  3. Throughput: out_ready=1, 100 random in_valid=1 pairs with mixed sgn.
//     The first out_valid appears exactly STAGES cycles after the first accept;
//     results are in order and match the reference model; no gaps.
//  4. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1.
//     in_ready falls after STAGES accepts; p holds stable; after release, all
//     STAGES results drain in order with nothing lost.
//  5. Reset mid-stream: pulse rst_n low asynchronously with 3 products in flight.
//     out_valid=0 and p=0 immediately; after release, the next product is correct
//     and no stale result appears.
//  6. Sweep: parameter sets W in {4,8,16} x STAGES in {1,2,4}. Exhaustive for W=4
//     (both sgn), random for larger W; all bit-exact.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared elaboration-time helpers for the pipelined Wallace-tree multiplier.
package mult_pkg;

  // Partial-product rows: W operand rows plus one Baugh-Wooley constant row.
  function automatic int unsigned pp_rows(input int unsigned w);
    return w + 1;
  endfunction

  // Rows left after one 3:2 level: each full group of three becomes two.
  function automatic int unsigned rows_after(input int unsigned n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Row count at the input of CSA level lvl (lvl == depth gives the final two).
  function automatic int unsigned rows_at_level(input int unsigned w, input int unsigned lvl);
    int unsigned n;
    n = pp_rows(w);
    for (int unsigned i = 0; i < lvl; i++) n = rows_after(n);
    return n;
  endfunction

  // Number of 3:2 levels needed to reduce all partial products to two rows.
  function automatic int unsigned csa_depth(input int unsigned w);
    int unsigned n;
    int unsigned d;
    n = pp_rows(w);
    d = 0;
    while (n > 2) begin
      n = rows_after(n);
      d++;
    end
    return d;
  endfunction

  // Baugh-Wooley correction: ones at weights w and 2w-1.
  function automatic logic [63:0] bw_const(input int unsigned w);
    return (64'd1 << w) | (64'd1 << (2 * w - 1));
  endfunction

  // Stage (0-based) holding CSA level lvl; levels spread evenly over s-1 stages.
  function automatic int unsigned level_stage(input int unsigned lvl, input int unsigned d,
                                              input int unsigned s);
    if (s <= 1) return 0;
    return (lvl * (s - 1)) / d;
  endfunction

  // True when lvl is the first CSA level of its stage (its input comes from a register or PPs).
  function automatic bit first_in_stage(input int unsigned lvl, input int unsigned d,
                                        input int unsigned s);
    if (lvl == 0) return 1'b1;
    return level_stage(lvl - 1, d, s) != level_stage(lvl, d, s);
  endfunction

  // Count of CSA levels completed before stage k begins.
  function automatic int unsigned levels_before_stage(input int unsigned k, input int unsigned d,
                                                      input int unsigned s);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned l = 0; l < d; l++) if (level_stage(l, d, s) < k) cnt++;
    return cnt;
  endfunction

  // Last CSA level in stage k, or -1 when the stage only carries rows through.
  function automatic int last_level_in_stage(input int unsigned k, input int unsigned d,
                                             input int unsigned s);
    int r;
    r = -1;
    for (int unsigned l = 0; l < d; l++) if (level_stage(l, d, s) == k) r = int'(l);
    return r;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One 3:2 carry-save level: bitwise full adders, carry row pre-shifted by one.
module csa_row #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  logic [WIDTH-2:0] maj;

  // Carry out of the top bit falls off: the result is taken modulo 2^WIDTH.
  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj     = (a_i[WIDTH-2:0] & b_i[WIDTH-2:0]) |
                   (a_i[WIDTH-2:0] & c_i[WIDTH-2:0]) |
                   (b_i[WIDTH-2:0] & c_i[WIDTH-2:0]);
  assign carry_o = {maj, 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined W x W Wallace-tree multiplier, unsigned or Baugh-Wooley signed per transaction.
module wallace_mult_pipe
  import mult_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int unsigned PW   = 2 * W;
  localparam int unsigned NROW = pp_rows(W);
  localparam int unsigned NLVL = csa_depth(W);
  localparam int unsigned S    = STAGES;
  localparam logic [PW-1:0] BW_C = PW'(bw_const(W));

  logic [NROW-1:0][PW-1:0] pp;
  logic [S:1]              v_q, v_d, rdy;
  logic [S:0]              v_chain;
  logic [1:0][PW-1:0]      fin_rows;
  logic [PW-1:0]           p_d, p_q;

  // Partial products; in signed mode the MSB row/column bits (except the corner) invert.
  for (genvar j = 0; j < W; j++) begin : g_pp
    localparam logic [W-1:0] INV_MASK = (j == W - 1) ? {1'b0, {(W-1){1'b1}}}
                                                     : {1'b1, {(W-1){1'b0}}};
    assign pp[j] = PW'((x & {W{y[j]}}) ^ (INV_MASK & {W{sgn}})) << j;
  end
  assign pp[W] = sgn ? BW_C : '0;

  // A stage can load when it is empty or everything downstream of it can move.
  for (genvar k = 1; k <= S; k++) begin : g_rdy
    assign rdy[k] = out_ready | ~(&v_q[S:k]);
  end

  assign v_chain   = {v_q, in_valid};
  assign in_ready  = rdy[1];
  assign out_valid = v_q[S];

  // Valid flags shift forward where the stage is ready, otherwise hold.
  always_comb begin
    v_d = (rdy & v_chain[S-1:0]) | (~rdy & v_q);
  end

  // Valid flag register; reset empties the pipe asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  // CSA levels; each takes rows from the previous level or the register opening its stage.
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int unsigned NI = rows_at_level(W, l);
    localparam int unsigned NG = NI / 3;
    localparam int unsigned NR = NI % 3;
    localparam int unsigned NO = 2 * NG + NR;
    localparam int unsigned ST = level_stage(l, NLVL, S);

    logic [NI-1:0][PW-1:0] rin;
    logic [NO-1:0][PW-1:0] rout;

    if (!first_in_stage(l, NLVL, S)) begin : g_chain
      assign rin = g_lvl[l-1].rout;
    end else if (ST == 0) begin : g_from_pp
      assign rin = pp;
    end else begin : g_from_reg
      assign rin = g_stg[ST].rows_q;
    end

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_row #(.WIDTH(PW)) u_csa (
        .a_i    (rin[3*g]),
        .b_i    (rin[3*g+1]),
        .c_i    (rin[3*g+2]),
        .sum_o  (rout[2*g]),
        .carry_o(rout[2*g+1])
      );
    end

    for (genvar r = 0; r < NR; r++) begin : g_pass
      assign rout[2*NG+r] = rin[3*NG+r];
    end
  end

  // Carry-save pipeline registers between stages 1..S-1.
  for (genvar k = 1; k < S; k++) begin : g_stg
    localparam int unsigned LB   = levels_before_stage(k, NLVL, S);
    localparam int unsigned NRW  = rows_at_level(W, LB);
    localparam int          LAST = last_level_in_stage(k - 1, NLVL, S);

    logic [NRW-1:0][PW-1:0] rows_d, rows_q;

    if (LAST >= 0) begin : g_src_lvl
      assign rows_d = g_lvl[LAST].rout;
    end else if (k == 1) begin : g_src_pp
      assign rows_d = pp;
    end else begin : g_src_stg
      assign rows_d = g_stg[k-1].rows_q;
    end

    // Capture only real transactions so bubbles do not disturb held data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      rows_q <= '0;
      else if (rdy[k] && v_chain[k-1]) rows_q <= rows_d;
    end
  end

  if (S == 1) begin : g_fin_comb
    assign fin_rows = g_lvl[NLVL-1].rout;
  end else begin : g_fin_reg
    assign fin_rows = g_stg[S-1].rows_q;
  end

  assign p_d = fin_rows[0] + fin_rows[1];

  // Final carry-propagate result register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      p_q <= '0;
    else if (rdy[S] && v_chain[S-1]) p_q <= p_d;
  end

  assign p = p_q;

endmodule
